// File: rtl/router_fsm_param.sv
// Router control FSM: decodes the header destination and sequences header/payload/parity loads into NUM_PORTS FIFOs.
// Moore outputs with one edge per transition; busy stalls the source, while drops keep busy low so the source can drain.
module router_fsm_param #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic                 write_enb_reg,
    output logic                 drop_state,
    output logic                 timeout_err,
    output logic [ADDR_W-1:0]    dest_q
);
    localparam int SEL_N = 1 << ADDR_W;
    localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (WAIT_TIMEOUT > 0) ? CNT_W'(WAIT_TIMEOUT - 1) : '0;
    localparam logic [ADDR_W:0]   PORT_LIM = (ADDR_W + 1)'(NUM_PORTS);

    typedef enum logic [3:0] {
        DECODE          = 4'd0,
        LOAD_FIRST      = 4'd1,
        LOAD_DATA       = 4'd2,
        LOAD_PARITY     = 4'd3,
        CHECK_PARITY    = 4'd4,
        FIFO_FULL       = 4'd5,
        LOAD_AFTER_FULL = 4'd6,
        WAIT_EMPTY      = 4'd7,
        DROP            = 4'd8
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [SEL_N-1:0] empty_ext;
    logic [SEL_N-1:0] srst_ext;
    logic             addr_ok;
    logic             timeout_hit;
    logic             srst_hit;

    // Zero-extend per-port flags so any ADDR_W-bit index is in range; missing ports read as 0.
    assign empty_ext   = SEL_N'(fifo_empty);
    assign srst_ext    = SEL_N'(soft_reset);
    assign addr_ok     = {1'b0, data_in} < PORT_LIM;
    assign timeout_hit = (WAIT_TIMEOUT > 0) && (wait_cnt == CNT_LAST);
    assign srst_hit    = (state != DECODE) && srst_ext[dest_q];

    always_comb begin
        state_nxt = state;
        case (state)
            DECODE: begin
                if (pkt_valid) begin
                    if (!addr_ok)                 state_nxt = DROP;
                    else if (empty_ext[data_in])  state_nxt = LOAD_FIRST;
                    else                          state_nxt = WAIT_EMPTY;
                end
            end
            LOAD_FIRST:   state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_nxt = FIFO_FULL;
                else if (!pkt_valid) state_nxt = LOAD_PARITY;
            end
            LOAD_PARITY:  state_nxt = CHECK_PARITY;
            CHECK_PARITY: state_nxt = fifo_full ? FIFO_FULL : DECODE;
            FIFO_FULL:    state_nxt = fifo_full ? FIFO_FULL : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_nxt = DECODE;
                else if (low_pkt_valid) state_nxt = LOAD_PARITY;
                else                    state_nxt = LOAD_DATA;
            end
            // An empty FIFO in the last allowed cycle still wins over the timeout.
            WAIT_EMPTY: begin
                if (empty_ext[dest_q]) state_nxt = LOAD_FIRST;
                else if (timeout_hit)  state_nxt = DROP;
            end
            DROP:         state_nxt = pkt_valid ? DROP : DECODE;
            default:      state_nxt = DECODE;
        endcase
        if (srst_hit) state_nxt = DECODE;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= DECODE;
            dest_q      <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= (state == WAIT_EMPTY) && (state_nxt == DROP);
            if ((state == DECODE) && pkt_valid) dest_q <= data_in;
            // Held at zero outside WAIT_EMPTY, so every entry starts a fresh count.
            if ((state != WAIT_EMPTY) || (WAIT_TIMEOUT == 0)) wait_cnt <= '0;
            else                                              wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign detect_add    = (state == DECODE);
    assign lfd_state     = (state == LOAD_FIRST);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL);
    assign rst_int_reg   = (state == CHECK_PARITY);
    assign drop_state    = (state == DROP);
    assign busy          = (state == LOAD_FIRST) || (state == LOAD_PARITY) || (state == CHECK_PARITY)
                        || (state == FIFO_FULL) || (state == LOAD_AFTER_FULL) || (state == WAIT_EMPTY);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER_FULL);

endmodule

// File: tb/tb_router_fsm_param.sv
// Testbench for router_fsm_param: directed packet scenarios plus random traffic against a behavioural model.
module tb_router_fsm_param;
    localparam int NP = 3;
    localparam int AW = 2;
    localparam int WT = 8;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          pkt_valid = 1'b0;
    logic [AW-1:0] data_in = '0;
    logic          parity_done = 1'b0;
    logic          low_pkt_valid = 1'b0;
    logic          fifo_full = 1'b0;
    logic [NP-1:0] fifo_empty = '1;
    logic [NP-1:0] soft_reset = '0;
    logic          detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic          busy, write_enb_reg, drop_state, timeout_err;
    logic [AW-1:0] dest_q;

    router_fsm_param #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(WT)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy), .write_enb_reg(write_enb_reg),
        .drop_state(drop_state), .timeout_err(timeout_err), .dest_q(dest_q)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: phase of the current packet, its destination and how long it has waited.
    typedef enum {P_IDLE, P_HDR, P_BODY, P_PAR, P_CHK, P_STALL, P_RESUME, P_WAIT, P_DISCARD} phase_t;
    phase_t m_ph = P_IDLE;
    int     m_dest = 0;
    int     m_waited = 0;
    bit     m_terr = 1'b0;

    logic [9:0] dut_outs;
    assign dut_outs = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                       busy, write_enb_reg, drop_state, timeout_err};

    function automatic logic [9:0] m_outs();
        bit b, w;
        b = m_ph inside {P_HDR, P_PAR, P_CHK, P_STALL, P_RESUME, P_WAIT};
        w = m_ph inside {P_BODY, P_PAR, P_RESUME};
        return {m_ph == P_IDLE, m_ph == P_HDR, m_ph == P_BODY, m_ph == P_RESUME, m_ph == P_STALL,
                m_ph == P_CHK, b, w, m_ph == P_DISCARD, m_terr};
    endfunction

    task automatic m_reset();
        m_ph = P_IDLE; m_dest = 0; m_waited = 0; m_terr = 1'b0;
    endtask

    task automatic m_step();
        phase_t nx = m_ph;
        bit     te = 1'b0;
        case (m_ph)
            P_IDLE:    if (pkt_valid) begin
                           if (int'(data_in) >= NP)    nx = P_DISCARD;
                           else if (fifo_empty[data_in]) nx = P_HDR;
                           else                          nx = P_WAIT;
                       end
            P_HDR:     nx = P_BODY;
            P_BODY:    if (fifo_full) nx = P_STALL; else if (!pkt_valid) nx = P_PAR;
            P_PAR:     nx = P_CHK;
            P_CHK:     nx = fifo_full ? P_STALL : P_IDLE;
            P_STALL:   if (!fifo_full) nx = P_RESUME;
            P_RESUME:  nx = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
            P_WAIT:    if (fifo_empty[m_dest]) nx = P_HDR;
                       else if (m_waited + 1 >= WT) begin nx = P_DISCARD; te = 1'b1; end
            P_DISCARD: if (!pkt_valid) nx = P_IDLE;
            default:   nx = P_IDLE;
        endcase
        if (m_ph != P_IDLE && m_dest < NP && soft_reset[m_dest]) begin
            nx = P_IDLE; te = 1'b0;
        end
        m_waited = (m_ph == P_WAIT && nx == P_WAIT) ? m_waited + 1 : 0;
        if (m_ph == P_IDLE && pkt_valid) m_dest = int'(data_in);
        m_ph = nx;
        m_terr = te;
    endtask

    task automatic cyc(input bit pv, input logic [AW-1:0] d, input bit pd, input bit lpv, input bit ff,
                       input logic [NP-1:0] fe, input logic [NP-1:0] sr);
        pkt_valid = pv; data_in = d; parity_done = pd; low_pkt_valid = lpv;
        fifo_full = ff; fifo_empty = fe; soft_reset = sr;
        @(posedge clock);
        m_step();
        @(negedge clock);
        check("outs", {22'd0, dut_outs}, {22'd0, m_outs()});
        check("dest_q", {30'd0, dest_q}, m_dest);
    endtask

    int wen_cnt;

    initial begin
        m_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outs", {22'd0, dut_outs}, 32'h200);
        check("reset_dest", {30'd0, dest_q}, 0);
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0, 3'b111, 0);

        // Normal packet to port 1 with four payload cycles.
        wen_cnt = 0;
        cyc(1, 1, 0, 0, 0, 3'b111, 0);
        check("t1_lfd", lfd_state, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 3'b111, 0);
            wen_cnt += int'(write_enb_reg);
        end
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        wen_cnt += int'(write_enb_reg);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        check("t1_chk", rst_int_reg, 1);
        wen_cnt += int'(write_enb_reg);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        check("t1_decode", detect_add, 1);
        check("t1_dest", {30'd0, dest_q}, 1);
        check("t1_wen_cycles", wen_cnt, 5);

        // Invalid address: drop while streaming.
        cyc(1, 3, 0, 0, 0, 3'b111, 0);
        for (int i = 0; i < 3; i++) begin
            check("t2_drop", {drop_state, busy, write_enb_reg, timeout_err}, 4'b1000);
            cyc(1, 0, 0, 0, 0, 3'b111, 0);
        end
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        check("t2_decode", detect_add, 1);

        // Wait timeout on port 2.
        cyc(1, 2, 0, 0, 0, 3'b011, 0);
        for (int i = 0; i < WT; i++) begin
            check("t3_wait_busy", {busy, drop_state}, 2'b10);
            cyc(1, 0, 0, 0, 0, 3'b011, 0);
        end
        check("t3_timeout", {drop_state, timeout_err}, 2'b11);
        cyc(1, 0, 0, 0, 0, 3'b011, 0);
        check("t3_err_pulse", {drop_state, timeout_err}, 2'b10);
        cyc(0, 0, 0, 0, 0, 3'b011, 0);

        // FIFO empties in the last allowed wait cycle.
        cyc(1, 2, 0, 0, 0, 3'b011, 0);
        for (int i = 0; i < WT - 1; i++) cyc(1, 0, 0, 0, 0, 3'b011, 0);
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        check("t3b_late_empty", {lfd_state, timeout_err, drop_state}, 3'b100);
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);

        // FIFO full: all three resume exits.
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 0, 1, 3'b111, 0);
        cyc(1, 0, 0, 0, 1, 3'b111, 0);
        check("t4_full", full_state, 1);
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        check("t4_laf", laf_state, 1);
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        check("t4_resume_data", ld_state, 1);
        cyc(1, 0, 0, 0, 1, 3'b111, 0);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        cyc(0, 0, 0, 1, 0, 3'b111, 0);
        check("t4_resume_parity", {write_enb_reg, busy, ld_state}, 3'b110);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 0, 1, 3'b111, 0);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);
        cyc(0, 0, 1, 0, 0, 3'b111, 0);
        check("t4_resume_done", detect_add, 1);

        // Soft reset: only the selected port's bit matters.
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 0, 0, 3'b111, 3'b010);
        check("t5_other_srst", ld_state, 1);
        cyc(1, 0, 0, 0, 0, 3'b111, 3'b001);
        check("t5_own_srst", detect_add, 1);
        cyc(0, 0, 0, 0, 0, 3'b111, 0);

        // Asynchronous reset while stalled.
        cyc(1, 1, 0, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 0, 1, 3'b111, 0);
        check("t6_pre_full", full_state, 1);
        #2 resetn = 1'b0;
        #1;
        check("t6_async_outs", {22'd0, dut_outs}, 32'h200);
        check("t6_async_dest", {30'd0, dest_q}, 0);
        m_reset();
        pkt_valid = 1'b0; fifo_full = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        cyc(0, 0, 0, 0, 0, 3'b111, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                ($urandom_range(0, 3) == 0) ? NP'(0) : NP'($urandom),
                ($urandom_range(0, 15) == 0) ? NP'($urandom) : NP'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
